// File: rtl/vdp_cpu_port.sv
// CPU-side port of the VDP: 98h/99h/9Bh decode, register file, VRAM address counter,
// read-ahead latch and a single-outstanding request channel to the video memory arbiter.
module vdp_cpu_port #(
  parameter int unsigned ADDR_BITS = 14,
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [7:0]  RST_STAT  = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_wr,
  input  logic                    cpu_rd,
  input  logic [1:0]              cpu_port,
  input  logic [7:0]              cpu_din,
  output logic [7:0]              cpu_dout,
  output logic                    cpu_wait,
  output logic                    overrun,
  output logic [8*NUM_REGS-1:0]   regs,
  input  logic [7:0]              stat_in,
  output logic                    stat_rd,
  output logic [ADDR_BITS-1:0]    vram_addr,
  output logic [7:0]              vram_wdata,
  output logic                    vram_we,
  output logic                    vram_req,
  input  logic                    vram_ack,
  input  logic [7:0]              vram_rdata
);

  localparam bit IND_EN   = (NUM_REGS > 17);
  localparam bit R14_WRAP = (ADDR_BITS > 14) && (NUM_REGS > 14);

  typedef enum logic [1:0] {IDLE, WRITE, PREFETCH} state_t;

  state_t               state;
  logic [7:0]           rf     [NUM_REGS];
  logic [7:0]           rf_nxt [NUM_REGS];
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           rd_latch;
  logic [7:0]           first_byte;
  logic                 toggle;

  logic                 wr_c, rd_c;
  logic                 data_acc_c, data_ok_c;
  logic                 ctrl_wr_c, ctrl_rd_c, ind_wr_c;
  logic                 reg_set_c, addr_set_c, pf_req_c;
  logic                 ack_c, carry_c, r14_upd_c, r17_inc_c;
  logic                 reg_we_c;
  logic [5:0]           reg_idx_c;
  logic [7:0]           reg_wdata_c;
  logic [7:0]           r14_c, r14_wrap_c;
  logic [5:0]           r17_idx_c;
  logic                 r17_hold_c;
  logic [ADDR_BITS-1:0] set_addr_c, base_addr_c, inc_addr_c, next_addr_c;

  // R14 (high address bits) and R17 (indirect pointer) exist only on larger register files
  if (NUM_REGS > 14) begin : g_r14
    assign r14_c = rf[14];
  end else begin : g_no_r14
    assign r14_c = 8'h00;
  end

  if (NUM_REGS > 17) begin : g_r17
    assign r17_idx_c  = rf[17][5:0];
    assign r17_hold_c = rf[17][7];
  end else begin : g_no_r17
    assign r17_idx_c  = 6'd0;
    assign r17_hold_c = 1'b0;
  end

  // Address bits above 13 come from R14 and feed back into it on a 16K carry
  if (ADDR_BITS > 14) begin : g_wide
    always_comb begin
      set_addr_c = {r14_c[ADDR_BITS-15:0], cpu_din[5:0], first_byte};
      r14_wrap_c = {r14_c[7:ADDR_BITS-14], inc_addr_c[ADDR_BITS-1:14]};
    end
  end else begin : g_narrow
    always_comb begin
      set_addr_c = {cpu_din[5:0], first_byte};
      r14_wrap_c = r14_c;
    end
  end

  always_comb begin
    wr_c        = cpu_wr;
    rd_c        = cpu_rd & ~cpu_wr;
    data_acc_c  = (wr_c | rd_c) && (cpu_port == 2'd0);
    data_ok_c   = data_acc_c && !vram_req;
    ctrl_wr_c   = wr_c && (cpu_port == 2'd1);
    ctrl_rd_c   = rd_c && (cpu_port == 2'd1);
    ind_wr_c    = IND_EN && wr_c && (cpu_port == 2'd3);
    reg_set_c   = ctrl_wr_c && toggle && cpu_din[7];
    addr_set_c  = ctrl_wr_c && toggle && !cpu_din[7];
    pf_req_c    = addr_set_c && !cpu_din[6];
    ack_c       = vram_req && vram_ack;

    reg_we_c    = reg_set_c || ind_wr_c;
    reg_idx_c   = reg_set_c ? cpu_din[5:0] : r17_idx_c;
    reg_wdata_c = reg_set_c ? first_byte : cpu_din;
    r17_inc_c   = ind_wr_c && !r17_hold_c;

    // A new address set during a request still receives the post-ack increment
    base_addr_c = addr_set_c ? set_addr_c : addr;
    inc_addr_c  = base_addr_c + ADDR_BITS'(1);
    next_addr_c = ack_c ? inc_addr_c : base_addr_c;
    carry_c     = &base_addr_c[13:0];
    r14_upd_c   = R14_WRAP && ack_c && carry_c;
  end

  // Next register-file contents: direct/indirect write, then pointer and carry updates
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_nxt[i] = rf[i];
      if (reg_we_c && (reg_idx_c == 6'(i))) rf_nxt[i] = reg_wdata_c;
      if ((i == 17) && r17_inc_c) rf_nxt[i][5:0] = r17_idx_c + 6'd1;
      if ((i == 14) && r14_upd_c) rf_nxt[i] = r14_wrap_c;
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NUM_REGS; i++) regs[8*i +: 8] = rf[i];
  end

  always_comb begin
    unique case (cpu_port)
      2'd0:    cpu_dout = rd_latch;
      2'd1:    cpu_dout = stat_in;
      default: cpu_dout = RST_STAT;
    endcase
  end

  assign cpu_wait = vram_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= 8'h00;
      addr       <= '0;
      rd_latch   <= 8'h00;
      first_byte <= 8'h00;
      toggle     <= 1'b0;
      overrun    <= 1'b0;
      stat_rd    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
      vram_we    <= 1'b0;
      vram_req   <= 1'b0;
    end else begin
      rf      <= rf_nxt;
      addr    <= next_addr_c;
      stat_rd <= ctrl_rd_c;
      overrun <= data_acc_c && vram_req;

      if (ctrl_wr_c) begin
        toggle <= ~toggle;
        if (!toggle) first_byte <= cpu_din;
      end else if (ctrl_rd_c || data_acc_c) begin
        toggle <= 1'b0;
      end

      // A read-address set while busy moves the counter but its prefetch is dropped
      case (state)
        IDLE: begin
          if (data_ok_c && wr_c) begin
            state      <= WRITE;
            vram_req   <= 1'b1;
            vram_we    <= 1'b1;
            vram_addr  <= addr;
            vram_wdata <= cpu_din;
            rd_latch   <= cpu_din;
          end else if (data_ok_c) begin
            state     <= PREFETCH;
            vram_req  <= 1'b1;
            vram_we   <= 1'b0;
            vram_addr <= addr;
          end else if (pf_req_c) begin
            state     <= PREFETCH;
            vram_req  <= 1'b1;
            vram_we   <= 1'b0;
            vram_addr <= set_addr_c;
          end
        end
        WRITE, PREFETCH: begin
          if (ack_c) begin
            state    <= IDLE;
            vram_req <= 1'b0;
            if (state == PREFETCH) rd_latch <= vram_rdata;
          end
        end
        default: begin
          state    <= IDLE;
          vram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: a 14-bit/8-register and a 17-bit/48-register instance driven
// with the same port traffic, each checked every cycle against a transaction-level model.
module tb_vdp_cpu_port;

  logic clk = 1'b0;
  logic reset;
  logic cpu_wr, cpu_rd;
  logic [1:0] cpu_port;
  logic [7:0] cpu_din, stat_in;

  logic [7:0]   dout0, dout1;
  logic         wait0, wait1, ovr0, ovr1, srd0, srd1;
  logic [63:0]  regs0;
  logic [383:0] regs1;
  logic [13:0]  vaddr0;
  logic [16:0]  vaddr1;
  logic [7:0]   wd0, wd1, rdat0, rdat1;
  logic         we0, we1, req0, req1, ack0, ack1;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  vdp_cpu_port #(.ADDR_BITS(14), .NUM_REGS(8), .RST_STAT(8'hFF)) u_dut0 (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_port(cpu_port),
    .cpu_din(cpu_din), .cpu_dout(dout0), .cpu_wait(wait0), .overrun(ovr0), .regs(regs0),
    .stat_in(stat_in), .stat_rd(srd0), .vram_addr(vaddr0), .vram_wdata(wd0), .vram_we(we0),
    .vram_req(req0), .vram_ack(ack0), .vram_rdata(rdat0));

  vdp_cpu_port #(.ADDR_BITS(17), .NUM_REGS(48), .RST_STAT(8'hFF)) u_dut1 (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_port(cpu_port),
    .cpu_din(cpu_din), .cpu_dout(dout1), .cpu_wait(wait1), .overrun(ovr1), .regs(regs1),
    .stat_in(stat_in), .stat_rd(srd1), .vram_addr(vaddr1), .vram_wdata(wd1), .vram_we(we1),
    .vram_req(req1), .vram_ack(ack1), .vram_rdata(rdat1));

  // Model state, one slot per instance
  logic [7:0]  m_regs [2][48];
  int unsigned m_addr [2];
  logic [7:0]  m_latch[2], m_first[2], m_wdata[2];
  bit          m_tog[2], m_busy[2], m_we[2], m_ovr[2], m_srd[2];
  int unsigned m_vaddr[2];

  logic [7:0] picks [8] = '{8'hFF, 8'h3F, 8'h7F, 8'h0E, 8'h8E, 8'h11, 8'h91, 8'h00};

  function automatic int unsigned ab(input int k);
    return (k == 0) ? 14 : 17;
  endfunction

  function automatic int unsigned nr(input int k);
    return (k == 0) ? 8 : 48;
  endfunction

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 48; i++) m_regs[k][i] = 8'h00;
      m_addr[k] = 0; m_latch[k] = 8'h00; m_first[k] = 8'h00; m_wdata[k] = 8'h00;
      m_tog[k] = 0; m_busy[k] = 0; m_we[k] = 0; m_ovr[k] = 0; m_srd[k] = 0; m_vaddr[k] = 0;
    end
  endtask

  task automatic start_req(input int k, input bit we, input int unsigned a, input logic [7:0] d);
    m_busy[k] = 1; m_we[k] = we; m_vaddr[k] = a; m_wdata[k] = d;
  endtask

  // One CPU-clock transaction step of the port, from the documented port rules
  task automatic model_step(input int k, input logic ack, input logic [7:0] rdata);
    bit wr, rd, was_busy;
    int unsigned nxt, lim, mask, idx;
    logic [7:0] old14, old17;
    wr = cpu_wr; rd = cpu_rd && !cpu_wr;
    lim  = 32'd1 << ab(k);
    mask = (32'd1 << (ab(k) - 14)) - 1;
    was_busy = m_busy[k];
    old14 = (nr(k) > 14) ? m_regs[k][14] : 8'h00;
    old17 = (nr(k) > 17) ? m_regs[k][17] : 8'h00;
    nxt = m_addr[k];
    m_ovr[k] = 0; m_srd[k] = 0;
    case (cpu_port)
      2'd0: if (wr || rd) begin
        m_tog[k] = 0;
        if (was_busy) m_ovr[k] = 1;
        else if (wr) begin start_req(k, 1, m_addr[k], cpu_din); m_latch[k] = cpu_din; end
        else start_req(k, 0, m_addr[k], 8'h00);
      end
      2'd1: if (wr) begin
        if (!m_tog[k]) begin m_first[k] = cpu_din; m_tog[k] = 1; end
        else begin
          m_tog[k] = 0;
          if (cpu_din[7]) begin
            idx = int'(cpu_din[5:0]);
            if (idx < nr(k)) m_regs[k][idx] = m_first[k];
          end else begin
            nxt = ((int'(old14) & mask) << 14) | (int'(cpu_din[5:0]) << 8) | int'(m_first[k]);
            if (!cpu_din[6] && !was_busy) start_req(k, 0, nxt, 8'h00);
          end
        end
      end else if (rd) begin
        m_srd[k] = 1; m_tog[k] = 0;
      end
      2'd3: if (wr && nr(k) > 17) begin
        idx = int'(old17[5:0]);
        if (idx < nr(k)) m_regs[k][idx] = cpu_din;
        if (!old17[7]) m_regs[k][17] = (m_regs[k][17] & 8'hC0) | {2'b00, old17[5:0] + 6'd1};
      end
      default: ;
    endcase
    if (was_busy && ack) begin
      if (!m_we[k]) m_latch[k] = rdata;
      m_busy[k] = 0;
      if (ab(k) > 14 && nr(k) > 14 && (nxt & 32'h3FFF) == 32'h3FFF)
        m_regs[k][14] = (old14 & ~8'(mask)) | 8'(((nxt + 1) % lim) >> 14);
      nxt = (nxt + 1) % lim;
    end
    m_addr[k] = nxt;
  endtask

  task automatic check_comb();
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      e = (cpu_port == 2'd0) ? m_latch[k] : (cpu_port == 2'd1) ? stat_in : 8'hFF;
      chk($sformatf("d%0d.cpu_dout", k), (k == 0) ? dout0 : dout1, e);
    end
  endtask

  task automatic check_regd();
    logic [383:0] e;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d.vram_req", k), (k == 0) ? req0 : req1, m_busy[k]);
      chk($sformatf("d%0d.cpu_wait", k), (k == 0) ? wait0 : wait1, m_busy[k]);
      chk($sformatf("d%0d.overrun", k), (k == 0) ? ovr0 : ovr1, m_ovr[k]);
      chk($sformatf("d%0d.stat_rd", k), (k == 0) ? srd0 : srd1, m_srd[k]);
      if (m_busy[k]) begin
        chk($sformatf("d%0d.vram_we", k), (k == 0) ? we0 : we1, m_we[k]);
        chk($sformatf("d%0d.vram_addr", k), (k == 0) ? 384'(vaddr0) : 384'(vaddr1), 384'(m_vaddr[k]));
        if (m_we[k]) chk($sformatf("d%0d.vram_wdata", k), (k == 0) ? wd0 : wd1, m_wdata[k]);
      end
      e = '0;
      for (int i = 0; i < nr(k); i++) e[8*i +: 8] = m_regs[k][i];
      chk($sformatf("d%0d.regs", k), (k == 0) ? 384'(regs0) : regs1, e);
    end
  endtask

  // Drive one cycle starting at a falling edge; ends at the next falling edge
  task automatic step(input logic wr, input logic rd, input logic [1:0] port, input logic [7:0] din,
                      input logic a0, input logic a1, input logic [7:0] rdv);
    cpu_wr = wr; cpu_rd = rd; cpu_port = port; cpu_din = din;
    ack0 = a0 && m_busy[0]; ack1 = a1 && m_busy[1];
    rdat0 = rdv; rdat1 = rdv;
    #1 check_comb();
    @(posedge clk);
    model_step(0, ack0, rdat0);
    model_step(1, ack1, rdat1);
    @(negedge clk);
    cyc++;
    check_regd();
  endtask

  task automatic rand_steps(input int n);
    int op;
    logic [7:0] d;
    logic a0, a1;
    for (int j = 0; j < n; j++) begin
      op = $urandom_range(0, 11);
      d  = ($urandom_range(0, 1) == 1) ? 8'($urandom) : picks[$urandom_range(0, 7)];
      a0 = ($urandom_range(0, 2) == 0);
      a1 = ($urandom_range(0, 2) == 0);
      stat_in = 8'($urandom);
      case (op)
        0, 1, 2: step(0, 0, 2'($urandom), d, a0, a1, 8'($urandom));
        3:       step(1, 0, 2'd0, d, a0, a1, 8'($urandom));
        4:       step(0, 1, 2'd0, d, a0, a1, 8'($urandom));
        5, 6:    step(1, 0, 2'd1, d, a0, a1, 8'($urandom));
        7:       step(0, 1, 2'd1, d, a0, a1, 8'($urandom));
        8:       step(1, 0, 2'd3, d, a0, a1, 8'($urandom));
        9:       step(op[0], ~op[0], 2'd2, d, a0, a1, 8'($urandom));
        10:      step(1, 1, 2'($urandom), d, a0, a1, 8'($urandom));
        default: step(0, 1, 2'd3, d, a0, a1, 8'($urandom));
      endcase
    end
  endtask

  initial begin
    reset = 1'b1; cpu_wr = 0; cpu_rd = 0; cpu_port = 2'd0; cpu_din = 8'h00;
    stat_in = 8'h00; ack0 = 0; ack1 = 0; rdat0 = 8'h00; rdat1 = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_regd();
    chk("reset.dout0", dout0, 8'h00);
    chk("reset.regs0", regs0, 64'h0);

    // Register write: R7 <= 07h
    step(1, 0, 2'd1, 8'h07, 0, 0, 8'h00);
    step(1, 0, 2'd1, 8'h87, 0, 0, 8'h00);
    chk("lit.r7_d0", regs0[8*7 +: 8], 8'h07);
    chk("lit.r7_d1", regs1[8*7 +: 8], 8'h07);
    chk("lit.no_req", req0, 1'b0);

    // Write address 1200h, data write A5h, dropped second write, ack, then read at 1201h
    step(1, 0, 2'd1, 8'h00, 0, 0, 8'h00);
    step(1, 0, 2'd1, 8'h52, 0, 0, 8'h00);
    step(1, 0, 2'd0, 8'hA5, 0, 0, 8'h00);
    chk("lit.wr_req", req0, 1'b1);
    chk("lit.wr_we", we0, 1'b1);
    chk("lit.wr_addr0", vaddr0, 14'h1200);
    chk("lit.wr_addr1", vaddr1, 17'h01200);
    step(1, 0, 2'd0, 8'h11, 0, 0, 8'h00);
    chk("lit.overrun", ovr0, 1'b1);
    chk("lit.ovr_addr", vaddr0, 14'h1200);
    chk("lit.ovr_wdata", wd0, 8'hA5);
    step(0, 0, 2'd0, 8'h00, 1, 1, 8'h00);
    chk("lit.ack_idle", req0, 1'b0);
    step(0, 1, 2'd0, 8'h00, 0, 0, 8'h00);
    chk("lit.rd_addr", vaddr0, 14'h1201);
    step(0, 0, 2'd0, 8'h00, 1, 1, 8'h33);

    // Read address 3FFFh, prefetch 5Ah, wrap to 0000h
    step(1, 0, 2'd1, 8'hFF, 0, 0, 8'h00);
    step(1, 0, 2'd1, 8'h3F, 0, 0, 8'h00);
    chk("lit.pf_addr0", vaddr0, 14'h3FFF);
    chk("lit.pf_addr1", vaddr1, 17'h03FFF);
    step(0, 0, 2'd0, 8'h00, 1, 1, 8'h5A);
    step(0, 1, 2'd0, 8'h00, 0, 0, 8'h00);
    chk("lit.pf_data", dout0, 8'h5A);
    chk("lit.wrap_addr", vaddr0, 14'h0000);
    step(0, 0, 2'd0, 8'h00, 1, 1, 8'h00);

    // 17-bit: R14=03h, write address 3FFFh -> carry into R14
    step(1, 0, 2'd1, 8'h03, 0, 0, 8'h00);
    step(1, 0, 2'd1, 8'h8E, 0, 0, 8'h00);
    step(1, 0, 2'd1, 8'hFF, 0, 0, 8'h00);
    step(1, 0, 2'd1, 8'h7F, 0, 0, 8'h00);
    step(1, 0, 2'd0, 8'hC3, 0, 0, 8'h00);
    chk("lit.hi_addr", vaddr1, 17'h0FFFF);
    step(0, 0, 2'd0, 8'h00, 1, 1, 8'h00);
    chk("lit.r14", regs1[8*14 +: 8], 8'h04);
    step(0, 1, 2'd0, 8'h00, 0, 0, 8'h00);
    chk("lit.carry_addr", vaddr1, 17'h10000);
    step(0, 0, 2'd0, 8'h00, 1, 1, 8'h00);

    // Control read clears the toggle
    stat_in = 8'h5C;
    step(1, 0, 2'd1, 8'h12, 0, 0, 8'h00);
    step(0, 1, 2'd1, 8'h00, 0, 0, 8'h00);
    chk("lit.stat", dout0, 8'h5C);
    chk("lit.stat_rd", srd0, 1'b1);
    step(1, 0, 2'd1, 8'h07, 0, 0, 8'h00);
    step(1, 0, 2'd1, 8'h85, 0, 0, 8'h00);
    chk("lit.r5", regs0[8*5 +: 8], 8'h07);
    step(0, 1, 2'd2, 8'h00, 0, 0, 8'h00);
    chk("lit.port2", dout0, 8'hFF);

    // Indirect writes via R17 on the 48-register instance
    step(1, 0, 2'd1, 8'h02, 0, 0, 8'h00);
    step(1, 0, 2'd1, 8'h91, 0, 0, 8'h00);
    step(1, 0, 2'd3, 8'hAA, 0, 0, 8'h00);
    step(1, 0, 2'd3, 8'hBB, 0, 0, 8'h00);
    chk("lit.ind_r2", regs1[8*2 +: 8], 8'hAA);
    chk("lit.ind_r3", regs1[8*3 +: 8], 8'hBB);
    chk("lit.ind_r17", regs1[8*17 +: 8], 8'h04);

    rand_steps(3000);

    // Reset while a request is outstanding drops it immediately
    step(0, 0, 2'd0, 8'h00, 1, 1, 8'h00);
    step(0, 0, 2'd0, 8'h00, 1, 1, 8'h00);
    step(1, 0, 2'd0, 8'h42, 0, 0, 8'h00);
    reset = 1'b1;
    #1;
    chk("lit.rst_req0", req0, 1'b0);
    chk("lit.rst_req1", req1, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_regd();
    chk("lit.rst_regs1", regs1, 384'h0);
    rand_steps(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
